// File: rtl/matmult_pkg.sv
// Package for the sequential N x N signed matrix multiplier.
// Holds the FSM state encoding and width helpers shared by the top level,
// the MAC datapath and the testbench.
package matmult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of an i/j/k loop counter for an n x n matrix (at least one bit).
  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Accumulator width: a full 2w-bit product plus headroom for n terms.
  function automatic int acc_w(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/matmult_nxn_seq_if.sv
// Operand/result bus of matmult_nxn_seq.
// Matrices are signed, row-major, element (r,c) at bits [(r*N+c)*W +: W].
//   in_valid/in_ready   : operand pair in_a/in_b handshake
//   out_valid/out_ready : result out_c/out_ovf handshake
// slave  = the multiplier, master = the producer/consumer driving it.
interface matmult_nxn_seq_if #(
  parameter int N = 3,
  parameter int W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [N*N*W-1:0] in_a;
  logic [N*N*W-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [N*N*W-1:0] out_c;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_c, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_c, out_ovf
  );
endinterface

// File: rtl/matmult_mac.sv
// Signed multiply-accumulate datapath for matmult_nxn_seq.
// One W x W -> 2W product is added per enabled cycle into a 2W+clog2(N)
// accumulator, which cannot overflow over N terms. res/ovf present the
// running sum (acc + current product) reduced to W bits: wrapped (SAT=0)
// or clamped (SAT=1); ovf flags a sum outside the signed W range.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the accumulator (new job)
//   en        : accumulate this cycle
//   last      : this is the k=N-1 term; accumulator restarts after it
//   a, b      : signed operands
//   res, ovf  : reduced sum and out-of-range flag (combinational)
module matmult_mac
  import matmult_pkg::*;
#(
  parameter int W   = 64,
  parameter int N   = 3,
  parameter int SAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                last,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic        [W-1:0] res,
  output logic                ovf
);
  localparam int AW = acc_w(W, N);

  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [AW-1:0]  prod_x, sum_v, max_v, min_v;
  logic signed [2*W-1:0] prod;

  // Both operands are sign-extended to 2W; the low 2W bits of that product
  // are the exact signed product.
  assign prod   = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
  assign prod_x = {{(AW-2*W){prod[2*W-1]}}, prod};
  assign sum_v  = acc_q + prod_x;

  assign max_v = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  assign min_v = ~max_v;

  always_comb begin
    ovf = (sum_v > max_v) || (sum_v < min_v);
    res = sum_v[W-1:0];
    if (SAT != 0) begin
      if (sum_v > max_v)      res = max_v[W-1:0];
      else if (sum_v < min_v) res = min_v[W-1:0];
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = last ? '0 : sum_v;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
endmodule

// File: rtl/matmult_nxn_seq.sv
// Sequential N x N signed matrix multiplier, C = A x B, one MAC per cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (dominates everything)
//   bus       : operand/result bus (slave side), see matmult_nxn_seq_if
//   dbg_state : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 exactly in IDLE; out_valid is 1 exactly in DONE and
// out_c/out_ovf hold steady there until out_ready is seen. The producer may
// keep in_valid high; it is only looked at in IDLE, and IDLE always lasts at
// least one cycle after a result is taken.
// Latency from accept edge to out_valid is N^3 cycles.
module matmult_nxn_seq
  import matmult_pkg::*;
#(
  parameter int N   = 3,
  parameter int W   = 64,
  parameter int SAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  matmult_nxn_seq_if.slave   bus,
  output state_e             dbg_state
);
  localparam int IW = idx_w(N);
  localparam int MW = N * N * W;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [MW-1:0]   a_q, a_d, b_q, b_d;
  logic [MW-1:0]   cw_q, cw_d;   // result being built during CALC
  logic [MW-1:0]   c_q, c_d;     // published result
  logic            ovfp_q, ovfp_d, ovf_q, ovf_d;

  logic            mac_clr, mac_en, mac_last, mac_ovf;
  logic [W-1:0]    mac_res;
  logic signed [W-1:0] op_a, op_b;
  int              a_idx, b_idx, c_idx;

  assign a_idx = (int'(i_q) * N + int'(k_q)) * W;
  assign b_idx = (int'(k_q) * N + int'(j_q)) * W;
  assign c_idx = (int'(i_q) * N + int'(j_q)) * W;
  assign op_a  = a_q[a_idx +: W];
  assign op_b  = b_q[b_idx +: W];

  matmult_mac #(.W(W), .N(N), .SAT(SAT)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .en   (mac_en),
    .last (mac_last),
    .a    (op_a),
    .b    (op_b),
    .res  (mac_res),
    .ovf  (mac_ovf)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    cw_d     = cw_q;
    c_d      = c_q;
    ovfp_d   = ovfp_q;
    ovf_d    = ovf_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    mac_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          ovfp_d  = 1'b0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        mac_en   = 1'b1;
        mac_last = (k_q == LAST);
        if (k_q == LAST) begin
          cw_d[c_idx +: W] = mac_res;
          ovfp_d = ovfp_q | mac_ovf;
          k_d    = '0;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              // Final element: publish the completed matrix on this edge,
              // including the element written just above.
              i_d     = '0;
              c_d     = cw_d;
              ovf_d   = ovfp_d;
              state_d = DONE;
            end else begin
              i_d = i_q + ONE;
            end
          end else begin
            j_d = j_q + ONE;
          end
        end else begin
          k_d = k_q + ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cw_q    <= '0;
      c_q     <= '0;
      ovfp_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cw_q    <= cw_d;
      c_q     <= c_d;
      ovfp_q  <= ovfp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_c     = c_q;
  assign bus.out_ovf   = ovf_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_matmult_nxn_seq.sv
// Testbench for matmult_nxn_seq: four instances cover N=3/W=16 wrap,
// N=3/W=8 saturate and wrap, and N=4/W=32 back-to-back random jobs.
module tb_matmult_nxn_seq;
  import matmult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic rst0;
  assign rst0 = rst | abort;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int acc_cyc[4];
  int last_acc3 = -1;
  logic vp0 = 1'b0, vp1 = 1'b0, vp2 = 1'b0, vp3 = 1'b0;

  matmult_nxn_seq_if #(.N(3), .W(16)) if0 ();
  matmult_nxn_seq_if #(.N(3), .W(8))  if1 ();
  matmult_nxn_seq_if #(.N(3), .W(8))  if2 ();
  matmult_nxn_seq_if #(.N(4), .W(32)) if3 ();
  state_e st0, st1, st2, st3;

  matmult_nxn_seq #(.N(3), .W(16), .SAT(0)) u0 (.clk(clk), .rst(rst0), .bus(if0.slave), .dbg_state(st0));
  matmult_nxn_seq #(.N(3), .W(8),  .SAT(1)) u1 (.clk(clk), .rst(rst),  .bus(if1.slave), .dbg_state(st1));
  matmult_nxn_seq #(.N(3), .W(8),  .SAT(0)) u2 (.clk(clk), .rst(rst),  .bus(if2.slave), .dbg_state(st2));
  matmult_nxn_seq #(.N(4), .W(32), .SAT(0)) u3 (.clk(clk), .rst(rst),  .bus(if3.slave), .dbg_state(st3));

  // ---------------- scoreboard queues: {ovf, c} ----------------
  logic [144:0] exp0_q[$];
  logic [72:0]  exp1_q[$];
  logic [72:0]  exp2_q[$];
  logic [512:0] exp3_q[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at t=%0t", name, $time);
  endtask

  // ---------------- matrix helpers / reference model ----------------
  function automatic logic [511:0] put(input logic [511:0] m, input int idx, input int w, input longint v);
    for (int q = 0; q < w; q++) m[idx*w+q] = v[q];
    return m;
  endfunction

  function automatic longint get_el(input logic [511:0] m, input int idx, input int w);
    longint v;
    for (int q = 0; q < 64; q++) v[q] = (q < w) ? m[idx*w+q] : m[idx*w+w-1];
    return v;
  endfunction

  function automatic logic [511:0] m_fill(input int n, input int w, input longint v);
    logic [511:0] m = '0;
    for (int x = 0; x < n*n; x++) m = put(m, x, w, v);
    return m;
  endfunction

  function automatic logic [511:0] m_seq(input int n, input int w, input longint s);
    logic [511:0] m = '0;
    for (int x = 0; x < n*n; x++) m = put(m, x, w, s * longint'(x + 1));
    return m;
  endfunction

  function automatic logic [511:0] m_ident(input int n, input int w, input longint s);
    logic [511:0] m = '0;
    for (int x = 0; x < n*n; x++) m = put(m, x, w, ((x / n) == (x % n)) ? s : 64'sd0);
    return m;
  endfunction

  function automatic void ref_mm(input logic [511:0] a, input logic [511:0] b, input int n, input int w,
                                 input int sat, output logic [511:0] c, output logic ovf);
    logic signed [127:0] s, pa, pb, hi, lo;
    c   = '0;
    ovf = 1'b0;
    hi  = 128'sd1;
    hi  = (hi <<< (w - 1)) - 128'sd1;
    lo  = -hi - 128'sd1;
    for (int r = 0; r < n; r++) begin
      for (int col = 0; col < n; col++) begin
        s = '0;
        for (int k = 0; k < n; k++) begin
          pa = get_el(a, r*n+k, w);
          pb = get_el(b, k*n+col, w);
          s  = s + pa * pb;
        end
        if (s > hi || s < lo) ovf = 1'b1;
        if (sat != 0 && s > hi) s = hi;
        else if (sat != 0 && s < lo) s = lo;
        c = put(c, r*n+col, w, s[63:0]);
      end
    end
  endfunction

  // ---------------- driver ----------------
  function automatic logic rdy(input int sel);
    case (sel)
      0:       return if0.in_ready;
      1:       return if1.in_ready && if2.in_ready;
      default: return if3.in_ready;
    endcase
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return exp0_q.size();
      1:       return exp1_q.size() + exp2_q.size();
      default: return exp3_q.size();
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [511:0] a, input logic [511:0] b);
    case (sel)
      0: begin
        if0.in_valid = v; if0.in_a = a[143:0]; if0.in_b = b[143:0];
      end
      1: begin
        if1.in_valid = v; if1.in_a = a[71:0]; if1.in_b = b[71:0];
        if2.in_valid = v; if2.in_a = a[71:0]; if2.in_b = b[71:0];
      end
      default: begin
        if3.in_valid = v; if3.in_a = a; if3.in_b = b;
      end
    endcase
  endtask

  task automatic send(input int sel, input logic [511:0] a, input logic [511:0] b);
    int t = 0;
    drive(sel, 1'b1, a, b);
    while (!rdy(sel) && t < 400) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 400) fail_timeout("send_wait_ready");
    @(posedge clk); #1;
    acc_cyc[sel] = cyc;
    if (sel == 3) begin
      if (last_acc3 >= 0) check("accept_spacing3", cyc - last_acc3, 66);
      last_acc3 = cyc;
    end
    drive(sel, 1'b0, a, b);
  endtask

  task automatic wait_idle(input int sel);
    int t = 0;
    while ((qsize(sel) != 0 || !rdy(sel)) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) fail_timeout("drain");
  endtask

  // ---------------- monitors ----------------
  logic [144:0] e0;
  logic [72:0]  e1, e2;
  logic [512:0] e3;

  always @(negedge clk) begin
    if (if0.out_valid === 1'b1 && !vp0) check("latency0", cyc - acc_cyc[0], 27);
    vp0 = (if0.out_valid === 1'b1);
    if (if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
      if (exp0_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL out0: unexpected result %0h", if0.out_c);
      end else begin
        e0 = exp0_q.pop_front();
        check("c0", if0.out_c, e0[143:0]);
        check("ovf0", if0.out_ovf, e0[144]);
      end
    end
  end

  always @(negedge clk) begin
    if (if1.out_valid === 1'b1 && !vp1) check("latency1", cyc - acc_cyc[1], 27);
    vp1 = (if1.out_valid === 1'b1);
    if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
      if (exp1_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL out1: unexpected result %0h", if1.out_c);
      end else begin
        e1 = exp1_q.pop_front();
        check("c1_sat", if1.out_c, e1[71:0]);
        check("ovf1_sat", if1.out_ovf, e1[72]);
      end
    end
  end

  always @(negedge clk) begin
    if (if2.out_valid === 1'b1 && !vp2) check("latency2", cyc - acc_cyc[1], 27);
    vp2 = (if2.out_valid === 1'b1);
    if (if2.out_valid === 1'b1 && if2.out_ready === 1'b1) begin
      if (exp2_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL out2: unexpected result %0h", if2.out_c);
      end else begin
        e2 = exp2_q.pop_front();
        check("c2_wrap", if2.out_c, e2[71:0]);
        check("ovf2_wrap", if2.out_ovf, e2[72]);
      end
    end
  end

  always @(negedge clk) begin
    if (if3.out_valid === 1'b1 && !vp3) check("latency3", cyc - acc_cyc[3], 64);
    vp3 = (if3.out_valid === 1'b1);
    if (if3.out_valid === 1'b1 && if3.out_ready === 1'b1) begin
      if (exp3_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL out3: unexpected result %0h", if3.out_c);
      end else begin
        e3 = exp3_q.pop_front();
        check("c3", if3.out_c, e3[511:0]);
        check("ovf3", if3.out_ovf, e3[512]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [511:0] a, b, c;
    logic         o;
    int           x;
    int           t;

    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    drive(3, 1'b0, '0, '0);
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    if2.out_ready = 1'b1;
    if3.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid0", if0.out_valid, 0);
    check("rst_in_ready0", if0.in_ready, 1);
    check("rst_out_c0", if0.out_c, 0);
    check("rst_out_ovf0", if0.out_ovf, 0);
    check("rst_out_c3", if3.out_c, 0);
    check("rst_state3", st3, IDLE);

    // identity x 1..9 = 1..9
    c = m_seq(3, 16, 1);
    exp0_q.push_back({1'b0, c[143:0]});
    send(0, m_ident(3, 16, 1), m_seq(3, 16, 1));
    wait_idle(0);

    // all 1 x all 2 = all 6
    c = m_fill(3, 16, 6);
    exp0_q.push_back({1'b0, c[143:0]});
    send(0, m_fill(3, 16, 1), m_fill(3, 16, 2));
    wait_idle(0);

    // -identity x 1..9 = -1..-9
    c = m_seq(3, 16, -1);
    exp0_q.push_back({1'b0, c[143:0]});
    send(0, m_ident(3, 16, -1), m_seq(3, 16, 1));
    wait_idle(0);

    // W=8: 127*127*3 = 48387 -> sat 127, wrap 3
    c = m_fill(3, 8, 127);
    exp1_q.push_back({1'b1, c[71:0]});
    c = m_fill(3, 8, 3);
    exp2_q.push_back({1'b1, c[71:0]});
    send(1, m_fill(3, 8, 127), m_fill(3, 8, 127));
    wait_idle(1);

    // W=8: -127*127*3 = -48387 -> sat -128, wrap 0xFD (-3)
    c = m_fill(3, 8, -128);
    exp1_q.push_back({1'b1, c[71:0]});
    c = m_fill(3, 8, -3);
    exp2_q.push_back({1'b1, c[71:0]});
    send(1, m_fill(3, 8, -127), m_fill(3, 8, 127));
    wait_idle(1);

    // W=8 in-range job: no ovf, both modes identical
    c = m_seq(3, 8, 1);
    exp1_q.push_back({1'b0, c[71:0]});
    exp2_q.push_back({1'b0, c[71:0]});
    send(1, m_ident(3, 8, 1), m_seq(3, 8, 1));
    wait_idle(1);

    // Backpressure: all 1 x 1..9 gives column sums 12,15,18 in each row
    if0.out_ready = 1'b0;
    c = '0;
    for (int q = 0; q < 9; q++) c = put(c, q, 16, longint'(12 + 3 * (q % 3)));
    exp0_q.push_back({1'b0, c[143:0]});
    send(0, m_fill(3, 16, 1), m_seq(3, 16, 1));
    t = 0;
    while (if0.out_valid !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) fail_timeout("bp_wait_valid");
    for (int n = 0; n < 10; n++) begin
      if0.in_valid = n[0];
      if0.in_a = m_fill(3, 16, longint'($urandom_range(1, 50)));
      if0.in_b = m_fill(3, 16, longint'($urandom_range(1, 50)));
      @(posedge clk); #1;
      check("bp_out_c_stable", if0.out_c, c);
      check("bp_in_ready_low", if0.in_ready, 0);
      check("bp_state_done", st0, DONE);
    end
    // Release while in_valid is high: must not be taken on the handshake edge.
    a = m_ident(3, 16, 1);
    b = m_seq(3, 16, 1);
    if0.in_a = a[143:0];
    if0.in_b = b[143:0];
    if0.in_valid = 1'b1;
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", if0.in_ready, 1);
    check("bp_release_out_valid", if0.out_valid, 0);
    check("bp_no_accept_on_handshake", st0, IDLE);
    check("idle_retains_out_c", if0.out_c, c);
    c = m_seq(3, 16, 1);
    exp0_q.push_back({1'b0, c[143:0]});
    @(posedge clk); #1;
    acc_cyc[0] = cyc;
    if0.in_valid = 1'b0;
    check("accept_after_idle", st0, CALC);
    wait_idle(0);

    // Reset in the middle of CALC: job discarded, outputs cleared
    send(0, m_seq(3, 16, 1), m_seq(3, 16, 2));
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    check("abort_state", st0, IDLE);
    check("abort_out_valid", if0.out_valid, 0);
    check("abort_out_c", if0.out_c, 0);
    check("abort_out_ovf", if0.out_ovf, 0);
    abort = 1'b0;
    c = m_seq(3, 16, 1);
    exp0_q.push_back({1'b0, c[143:0]});
    send(0, m_ident(3, 16, 1), m_seq(3, 16, 1));
    wait_idle(0);

    // N=4, W=32 back-to-back: first job at the negative extreme, then random
    for (int jn = 0; jn < 5; jn++) begin
      a = '0;
      b = '0;
      for (int q = 0; q < 16; q++) begin
        if (jn == 0) begin
          a = put(a, q, 32, -64'sd2147483648);
          b = put(b, q, 32, -64'sd2147483648);
        end else begin
          x = $urandom;
          a = put(a, q, 32, longint'(x));
          x = $urandom;
          b = put(b, q, 32, longint'(x));
        end
      end
      ref_mm(a, b, 4, 32, 0, c, o);
      exp3_q.push_back({o, c});
      send(3, a, b);
    end
    wait_idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/matmult_nxn_seq.md
MATMULT_NXN_SEQ -- requirements
Module: matmult_nxn_seq

Interface
REQ-001 SHALL have parameter N, default 3, matrix dimension (N x N), legal range 2..8.
REQ-002 SHALL have parameter W, default 64, signed element width, legal range 8..64.
REQ-003 SHALL have parameter SAT, default 0; 0 = wrap result modulo 2^W, 1 = saturate result to signed W range.
REQ-004 SHALL have port clk, in, 1, clock; all logic on the rising edge.
REQ-005 SHALL have port rst, in, 1, reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, in, 1, operand pair present.
REQ-007 SHALL have port in_ready, out, 1, block can accept operands.
REQ-008 SHALL have port in_a, in, N*N*W, matrix A, signed, row-major; element (r,c) at bits [(r*N+c)*W +: W].
REQ-009 SHALL have port in_b, in, N*N*W, matrix B, same packing as in_a.
REQ-010 SHALL have port out_valid, out, 1, result C present.
REQ-011 SHALL have port out_ready, in, 1, consumer takes result.
REQ-012 SHALL have port out_c, out, N*N*W, C = A x B, signed, same packing as in_a.
REQ-013 SHALL have port out_ovf, out, 1, at least one C element exceeded the signed W range.

Function
REQ-014 SHALL use an FSM with states IDLE, CALC and DONE; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 In IDLE, when in_valid=1, SHALL register in_a and in_b, clear the accumulator and the ovf-pending flag, and go to CALC on that edge (accept edge E0).
REQ-016 In CALC, SHALL perform one signed W x W -> 2W multiply-accumulate per cycle.
REQ-017 Loop order SHALL be i outer (row), j middle (column), k inner; each cycle adds A[i][k]*B[k][j].
REQ-018 Accumulator width SHALL be 2W+clog2(N) bits, so no internal overflow occurs.
REQ-019 On the k=N-1 cycle, SHALL write the final sum for (i,j) into the C register and reset the accumulator for the next element.
REQ-020 SAT=0: SHALL store the low W bits of the sum; SAT=1: SHALL clamp the sum to [-2^(W-1), 2^(W-1)-1].
REQ-021 Either mode: SHALL set ovf-pending if the sum lies outside the signed W range.
REQ-022 After N^3 CALC cycles SHALL go to DONE; out_valid SHALL be 1 from edge E0+N^3 onward (latency N^3 cycles; 27 for N=3).
REQ-023 out_c and out_ovf SHALL update only on the CALC->DONE transition and SHALL stay stable while out_valid=1.
REQ-024 In DONE, out_valid SHALL stay high until out_ready=1; on that edge SHALL go to IDLE and clear out_valid, so in_ready=1 in the next cycle.
REQ-025 out_c SHALL retain the last result in IDLE.
REQ-026 in_valid SHALL be ignored outside IDLE; no operand capture and no effect.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 in_valid SHALL NOT be accepted in the same cycle as the out_ready handshake (minimum one IDLE cycle between jobs).

Reset
REQ-029 rst SHALL dominate all other inputs in any state, including mid-CALC and mid-DONE.
REQ-030 On rst: state=IDLE, out_valid=0, out_c=0, out_ovf=0, accumulator, counters and operand registers=0; in_ready=1 in the cycle after rst deasserts.
REQ-031 A job interrupted by reset SHALL be discarded with no output produced.

Structure
REQ-032 Package matmult_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and an index-width helper constant/function (clog2 of N).
REQ-033 One sub-module, matmult_mac, SHALL contain the multiplier, accumulator and sat/wrap/ovf output stage, parameterised by W, N and SAT.
REQ-034 The top level SHALL contain the FSM, i/j/k counters, and the operand and result registers.

Verification
REQ-035 N=3, W=16, SAT=0, A=identity, B=1..9 -> out_c=1..9, out_ovf=0, out_valid rises exactly 27 cycles after accept.
REQ-036 N=3, W=16, A=all 1, B=all 2 -> every C element=6; A=-identity, B=1..9 -> C=-1..-9.
REQ-037 N=3, W=8, A=B=all 127: SAT=1 -> all C=127, out_ovf=1; SAT=0 -> all C=3 (48387 mod 256), out_ovf=1.
REQ-038 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid -> out_c stable, in_ready=0, no new capture; then out_ready=1 -> in_ready=1 next cycle.
REQ-039 Assert rst at CALC cycle 10, then run an identity job -> outputs zero during reset; new result correct, no residue from the aborted job.
REQ-040 Back-to-back jobs with N=4, W=32 against a random-matrix reference model -> all results match, and the minimum spacing between accept edges is 4^3+2 cycles.
